multicycle_ctrl: RTL and testbench

Moore-style FSM controller that sequences a shared-ALU, shared-memory multicycle RV32I datapath, which replaces the separate PC/branch adders of the single-cycle core. It decodes Op/funct3/funct7 and drives all mux selects, write enables and ALUControl each cycle. It also handles a memory ready handshake with a timeout. It sits beside the datapath top in place of the single-cycle control unit.

---
 rtl/multicycle_pkg.sv | 59 +++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes,
// ALU operation codes and datapath select values.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse operation requested by the FSM; the decoder refines it.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode shared by EXECR, EXECI and BEQ.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from immediate forms: addi never subtracts
                    3'b000:  alu_control = (op5 && funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing a shared-ALU, shared-memory multicycle RV32I datapath,
// with a bounded wait on the memory ready handshake.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Z,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       Memwrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       Regwrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr,
    output logic       mem_err,
    output logic [3:0] state_o
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_err_reg, mem_err_next;
    state_t     cur;
    logic [1:0] alu_op;
    logic       mem_wait, timeout;

    // While rst is high the outputs present FETCH values regardless of state.
    assign cur     = rst ? S_FETCH : state_reg;
    assign state_o = cur;
    assign mem_err = mem_err_reg;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (Op[5]),
        .alu_control (ALUControl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        mem_wait      = is_mem_state(cur) && !mem_ready;
        timeout       = mem_wait && (wait_cnt_reg == WAIT_LIMIT);
        wait_cnt_next = (mem_wait && !timeout) ? wait_cnt_reg + 8'd1 : 8'd0;
        mem_err_next  = mem_err_reg | timeout;
    end

    always_comb begin
        state_next    = cur;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        Memwrite      = 1'b0;
        IRWrite       = 1'b0;
        Regwrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        ImmSrc        = IMM_I;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;

        case (cur)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (Op == OP_SW) ? IMM_S : IMM_I;
                state_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                Regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                Memwrite = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                Regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                PCWrite    = Z;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_FETCH;
        endcase

        if (timeout) state_next = S_ERROR;

        if (rst) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            Memwrite      = 1'b0;
            Regwrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle's expected outputs are queued
// when inputs are driven and checked against the DUT mid-cycle.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       Z = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, Memwrite, IRWrite, Regwrite, illegal_instr, mem_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Z(Z),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .Memwrite(Memwrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .Regwrite(Regwrite), .ImmSrc(ImmSrc),
        .illegal_instr(illegal_instr), .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [21:0] val;
        logic [21:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0]  ir_op = 7'd0;
    logic [2:0]  ir_f3 = 3'd0;
    logic        ir_f7 = 1'b0;
    logic [21:0] obs;

    localparam logic [21:0] FULL    = 22'h3FFFFF;
    localparam logic [21:0] NO_SRCA = 22'h3F3FFF;
    localparam logic [21:0] NO_STAT = 22'h3FFFE0;

    assign obs = {PCWrite, AdrSrc, Memwrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, Regwrite, ImmSrc, illegal_instr, mem_err, state_o};

    function automatic logic [21:0] pk(input state_t st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic rw,
                                       input logic [1:0] imm, input logic ill, input logic err);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, imm, ill, err, 4'(st)};
    endfunction

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        ir_op = op;
        ir_f3 = f3;
        ir_f7 = f7;
    endtask

    task automatic check();
        exp_t x;
        x = sb_q.pop_front();
        n_cmp++;
        $display("%-14s state=%0d obs=%h exp=%h", x.tag, state_o, obs & x.mask, x.val & x.mask);
        assert ((obs & x.mask) === (x.val & x.mask)) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs & x.mask, x.val & x.mask);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic z, input logic rdy,
                        input logic [21:0] e, input logic [21:0] m);
        exp_t x;
        @(negedge clk);
        rst = r; Z = z; mem_ready = rdy;
        Op = ir_op; funct3 = ir_f3; funct7 = ir_f7;
        x.tag = tag; x.val = e; x.mask = m;
        sb_q.push_back(x);
        #1 check();
    endtask

    logic [21:0] f_rst, f_rdy, dec, dec_ill, execr_sub, execr_add, aluwb, madr_i, madr_s;
    logic [21:0] mread, mwb, beq_t, beq_n, jal_e, execi_and, execi_add, mwrite, err_e;

    initial begin
        f_rst     = pk(S_FETCH,    0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 0, 2'b00, 0,0);
        f_rdy     = pk(S_FETCH,    1,0,0,1, 2'b10,2'b00,2'b10, 3'b000, 0, 2'b00, 0,0);
        dec       = pk(S_DECODE,   0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 0, 2'b10, 0,0);
        dec_ill   = pk(S_DECODE,   0,0,0,0, 2'b00,2'b01,2'b01, 3'b000, 0, 2'b10, 1,0);
        execr_sub = pk(S_EXECR,    0,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 0, 2'b00, 0,0);
        execr_add = pk(S_EXECR,    0,0,0,0, 2'b00,2'b10,2'b00, 3'b000, 0, 2'b00, 0,0);
        aluwb     = pk(S_ALUWB,    0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1, 2'b00, 0,0);
        madr_i    = pk(S_MEMADR,   0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 0, 2'b00, 0,0);
        madr_s    = pk(S_MEMADR,   0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 0, 2'b01, 0,0);
        mread     = pk(S_MEMREAD,  0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00, 0,0);
        mwb       = pk(S_MEMWB,    0,0,0,0, 2'b01,2'b00,2'b00, 3'b000, 1, 2'b00, 0,0);
        beq_t     = pk(S_BEQ,      1,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 0, 2'b00, 0,0);
        beq_n     = pk(S_BEQ,      0,0,0,0, 2'b00,2'b10,2'b00, 3'b001, 0, 2'b00, 0,0);
        jal_e     = pk(S_JAL,      1,0,0,0, 2'b00,2'b01,2'b10, 3'b000, 0, 2'b00, 0,0);
        execi_and = pk(S_EXECI,    0,0,0,0, 2'b00,2'b10,2'b01, 3'b010, 0, 2'b00, 0,0);
        execi_add = pk(S_EXECI,    0,0,0,0, 2'b00,2'b10,2'b01, 3'b000, 0, 2'b00, 0,0);
        mwrite    = pk(S_MEMWRITE, 0,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00, 0,0);
        err_e     = pk(S_ERROR,    0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0, 2'b00, 0,1);

        // Reset held two cycles with mem_ready high: no enables may leak
        set_ir(OP_R, 3'b000, 1'b1);
        step("rst0", 1, 0, 1, f_rst, FULL);
        step("rst1", 1, 0, 1, f_rst, FULL);

        // R-type sub, then R-type with an unlisted funct3 (plain add)
        step("sub_fetch", 0, 0, 1, f_rdy, FULL);
        step("sub_decode", 0, 0, 1, dec, FULL);
        step("sub_execr", 0, 0, 1, execr_sub, FULL);
        step("sub_aluwb", 0, 0, 1, aluwb, FULL);
        set_ir(OP_R, 3'b001, 1'b0);
        step("sll_fetch", 0, 0, 1, f_rdy, FULL);
        step("sll_decode", 0, 0, 1, dec, FULL);
        step("sll_execr", 0, 0, 1, execr_add, FULL);
        step("sll_aluwb", 0, 0, 1, aluwb, FULL);

        // lw with three wait cycles; ready arrives exactly at the limit count
        set_ir(OP_LW, 3'b010, 1'b0);
        step("lw_fetch", 0, 0, 1, f_rdy, FULL);
        step("lw_decode", 0, 0, 1, dec, FULL);
        step("lw_memadr", 0, 0, 1, madr_i, FULL);
        for (int i = 0; i < 3; i++) step("lw_wait", 0, 0, 0, mread, FULL);
        step("lw_memread", 0, 0, 1, mread, FULL);
        step("lw_memwb", 0, 0, 1, mwb, FULL);

        // beq taken then not taken
        set_ir(OP_BEQ, 3'b000, 1'b0);
        step("beqt_fetch", 0, 1, 1, f_rdy, FULL);
        step("beqt_decode", 0, 1, 1, dec, FULL);
        step("beqt_beq", 0, 1, 1, beq_t, FULL);
        step("beqn_fetch", 0, 0, 1, f_rdy, FULL);
        step("beqn_decode", 0, 0, 1, dec, FULL);
        step("beqn_beq", 0, 0, 1, beq_n, FULL);

        // Unsupported opcode
        set_ir(7'b1111111, 3'b000, 1'b0);
        step("ill_fetch", 0, 0, 1, f_rdy, FULL);
        step("ill_decode", 0, 0, 1, dec_ill, FULL);

        // jal, addi-style andi, then addi with funct7 set (still add)
        set_ir(OP_JAL, 3'b000, 1'b0);
        step("jal_fetch", 0, 0, 1, f_rdy, FULL);
        step("jal_decode", 0, 0, 1, dec, FULL);
        step("jal_jal", 0, 0, 1, jal_e, FULL);
        step("jal_aluwb", 0, 0, 1, aluwb, FULL);
        set_ir(OP_I, 3'b111, 1'b0);
        step("andi_fetch", 0, 0, 1, f_rdy, FULL);
        step("andi_decode", 0, 0, 1, dec, FULL);
        step("andi_execi", 0, 0, 1, execi_and, NO_SRCA);
        step("andi_aluwb", 0, 0, 1, aluwb, FULL);
        set_ir(OP_I, 3'b000, 1'b1);
        step("addi_fetch", 0, 0, 1, f_rdy, FULL);
        step("addi_decode", 0, 0, 1, dec, FULL);
        step("addi_execi", 0, 0, 1, execi_add, NO_SRCA);
        step("addi_aluwb", 0, 0, 1, aluwb, FULL);

        // sw with memory stuck not-ready: timeout after 4 write cycles
        set_ir(OP_SW, 3'b010, 1'b0);
        step("sw_fetch", 0, 0, 1, f_rdy, FULL);
        step("sw_decode", 0, 0, 1, dec, FULL);
        step("sw_memadr", 0, 0, 1, madr_s, FULL);
        for (int i = 0; i < 4; i++) step("sw_memwrite", 0, 0, 0, mwrite, FULL);
        step("err_hold0", 0, 0, 0, err_e, FULL);
        step("err_hold1", 0, 0, 1, err_e, FULL);
        step("err_rst", 1, 0, 1, f_rst, NO_STAT);
        step("post_rst_idle", 0, 0, 0, f_rst, FULL);
        step("post_rst_fetch", 0, 0, 1, f_rdy, FULL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
